cf_sram_wb_banked: RTL



---
 rtl/cf_sram_wb_pkg.sv | 15 +
 rtl/cf_sram_wb_decode.sv | 34 +++
 rtl/cf_sram_wb_banked.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cf_sram_wb_pkg.sv
// rtl/cf_sram_wb_pkg.sv - shared types and helpers for the banked SRAM Wishbone slave
package cf_sram_wb_pkg;

  localparam int WB_DW = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cf_sram_wb_decode.sv
// rtl/cf_sram_wb_decode.sv - window hit, bank/word split and write-protect check
module cf_sram_wb_decode
  import cf_sram_wb_pkg::*;
#(
  parameter int          NUM_BANKS = 4,
  parameter int          WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  localparam int         AW        = clog2(WORDS),
  localparam int         BW        = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1,
  localparam int         W         = clog2(NUM_BANKS * WORDS * 4)
) (
  input  logic [31:2]          adr,
  input  logic                 we,
  input  logic [NUM_BANKS-1:0] wp,
  output logic                 hit,
  output logic [BW-1:0]        bank,
  output logic [AW-1:0]        word,
  output logic                 protect_err
);

  assign hit  = (adr[31:W] == BASE_ADDR[31:W]);
  assign word = adr[AW+1:2];

  generate
    if (NUM_BANKS > 1) begin : g_multi
      assign bank = adr[W-1:AW+2];
    end else begin : g_single
      assign bank = 1'b0;
    end
  endgenerate

  assign protect_err = we & wp[bank];

endmodule

// File: rtl/cf_sram_wb_banked.sv
// rtl/cf_sram_wb_banked.sv - Wishbone classic slave in front of NUM_BANKS single-port SRAM macros
module cf_sram_wb_banked
  import cf_sram_wb_pkg::*;
#(
  parameter int          NUM_BANKS = 4,
  parameter int          WORDS     = 1024,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  output logic [31:0]                wbs_dat_o,
  input  logic [NUM_BANKS-1:0]       wp_i,
  output logic [NUM_BANKS-1:0]       ram_en_o,
  output logic                       ram_we_o,
  output logic [3:0]                 ram_be_o,
  output logic [clog2(WORDS)-1:0]    ram_addr_o,
  output logic [31:0]                ram_wdata_o,
  input  logic [NUM_BANKS*WB_DW-1:0] ram_rdata_i
);

  localparam int         AW       = clog2(WORDS);
  localparam int         BW       = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1;
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 we_q;
  logic [BW-1:0]        bank_q;
  logic                 hit, protect_err;
  logic [BW-1:0]        bank;
  logic [AW-1:0]        word;
  logic                 accept, reject, ack_d, capture;
  logic [NUM_BANKS-1:0] en_d;
  logic                 unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  cf_sram_wb_decode #(
    .NUM_BANKS (NUM_BANKS),
    .WORDS     (WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .adr         (wbs_adr_i[31:2]),
    .we          (wbs_we_i),
    .wp          (wp_i),
    .hit         (hit),
    .bank        (bank),
    .word        (word),
    .protect_err (protect_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    reject  = 1'b0;
    ack_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (!hit || protect_err) begin
            reject  = 1'b1;
            state_d = RESP;
          end else begin
            accept  = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      // A dropped cyc here still leaves the write committed: the enable already fired.
      ACCESS: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (we_q) begin
          ack_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 2'd0) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      en_d[b] = accept && (bank == BW'(b));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= wbs_we_i;
        bank_q <= bank;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o   <= 1'b0;
      wbs_err_o   <= 1'b0;
      wbs_dat_o   <= '0;
      ram_en_o    <= '0;
      ram_we_o    <= 1'b0;
      ram_be_o    <= '0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else begin
      wbs_ack_o <= ack_d;
      wbs_err_o <= reject;
      if (reject) begin
        wbs_dat_o <= '0;
      end else if (capture) begin
        wbs_dat_o <= ram_rdata_i[{bank_q, 5'd0} +: WB_DW];
      end
      ram_en_o <= en_d;
      ram_we_o <= accept & wbs_we_i;
      if (accept) begin
        ram_be_o    <= wbs_sel_i;
        ram_addr_o  <= word;
        ram_wdata_o <= wbs_dat_i;
      end
    end
  end

endmodule
